// File: rtl/teclado_matricial_4x4_if.sv
// Keypad pin and key-code bundle between the matrix scanner (slave) and its
// consumer/keypad side (master).
interface teclado_matricial_4x4_if;
    logic [3:0] i_Fila;
    logic [3:0] o_Col;
    logic [3:0] o_Tecla;
    logic       o_Valida;
    logic       o_Presionada;

    modport slave (
        input  i_Fila,
        output o_Col,
        output o_Tecla,
        output o_Valida,
        output o_Presionada
    );

    modport master (
        output i_Fila,
        input  o_Col,
        input  o_Tecla,
        input  o_Valida,
        input  o_Presionada
    );
endinterface

// File: rtl/teclado_matricial_4x4.sv
// 4x4 matrix keypad scanner: rotating one-hot column drive, per-scan ghost-aware
// candidate, and press/release debounce over whole scans.
module teclado_matricial_4x4 #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    teclado_matricial_4x4_if.slave        kp
);
    localparam int             DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]     DEB_N    = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_t;

    logic [3:0]       fila_meta_q, fila_sync_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_idx_q;
    logic             acc_seen_q, acc_seen_d;
    logic             acc_multi_q, acc_multi_d;
    logic [3:0]       acc_key_q, acc_key_d;
    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       key_q, key_d;
    logic [3:0]       tecla_q, tecla_d;
    logic             valida_q, valida_d;

    logic       sample, eval, any_row, one_row;
    logic [1:0] row_idx;
    logic       seen_m, multi_m;
    logic [3:0] key_m, cnt_inc;
    logic       cand_key, cand_none;

    assign sample  = (div_q == DIV_LAST);
    assign eval    = sample && (col_idx_q == 2'd3);
    assign any_row = |fila_sync_q;
    assign one_row = $onehot(fila_sync_q);
    // Row encoder is only consulted when exactly one row is active.
    assign row_idx = {fila_sync_q[3] | fila_sync_q[2], fila_sync_q[3] | fila_sync_q[1]};

    // Merge this column's sample into the running scan result.
    assign seen_m    = acc_seen_q | any_row;
    assign multi_m   = acc_multi_q | (any_row && (!one_row || acc_seen_q));
    assign key_m     = (one_row && !acc_seen_q) ? {row_idx, col_idx_q} : acc_key_q;
    assign cand_none = !seen_m;
    assign cand_key  = seen_m && !multi_m;
    assign cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    always_comb begin
        acc_seen_d  = acc_seen_q;
        acc_multi_d = acc_multi_q;
        acc_key_d   = acc_key_q;
        if (eval) begin
            acc_seen_d  = 1'b0;
            acc_multi_d = 1'b0;
            acc_key_d   = 4'd0;
        end else if (sample) begin
            acc_seen_d  = seen_m;
            acc_multi_d = multi_m;
            acc_key_d   = key_m;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        tecla_d  = tecla_q;
        valida_d = 1'b0;
        if (eval) begin
            unique case (state_q)
                IDLE: if (cand_key) begin
                    key_d   = key_m;
                    cnt_d   = 4'd1;
                    state_d = DEB_PRESS;
                    if (DEB_N <= 4'd1) begin
                        state_d  = HELD;
                        tecla_d  = key_m;
                        valida_d = 1'b1;
                    end
                end
                DEB_PRESS: if (cand_key && key_m == key_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= DEB_N) begin
                        state_d  = HELD;
                        tecla_d  = key_m;
                        valida_d = 1'b1;
                    end
                end else if (cand_key) begin
                    key_d = key_m;
                    cnt_d = 4'd1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
                HELD: if (cand_none) begin
                    cnt_d   = 4'd1;
                    state_d = (DEB_N <= 4'd1) ? IDLE : DEB_RELEASE;
                end
                DEB_RELEASE: if (cand_none) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= DEB_N) state_d = IDLE;
                end else begin
                    state_d = HELD;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            fila_meta_q <= '0;
            fila_sync_q <= '0;
            div_q       <= '0;
            col_idx_q   <= 2'd0;
            acc_seen_q  <= 1'b0;
            acc_multi_q <= 1'b0;
            acc_key_q   <= 4'd0;
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            key_q       <= 4'd0;
            tecla_q     <= 4'd0;
            valida_q    <= 1'b0;
        end else begin
            fila_meta_q <= kp.i_Fila;
            fila_sync_q <= fila_meta_q;
            div_q       <= sample ? '0 : div_q + 1'b1;
            if (sample) col_idx_q <= col_idx_q + 2'd1;
            acc_seen_q  <= acc_seen_d;
            acc_multi_q <= acc_multi_d;
            acc_key_q   <= acc_key_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            tecla_q     <= tecla_d;
            valida_q    <= valida_d;
        end
    end

    assign kp.o_Col        = 4'b0001 << col_idx_q;
    assign kp.o_Tecla      = tecla_q;
    assign kp.o_Valida     = valida_q;
    assign kp.o_Presionada = (state_q == HELD) || (state_q == DEB_RELEASE);
endmodule

// File: tb/tb_teclado_matricial_4x4.sv
// Scoreboard bench for the keypad scanner: the stimulus pushes expected key codes,
// a monitor pops one on every o_Valida pulse. SCAN_DIV=4, DEBOUNCE_SCANS=2.
module tb_teclado_matricial_4x4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    teclado_matricial_4x4_if kp();

    teclado_matricial_4x4 #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .kp    (kp)
    );

    // Keypad model: key 4*r+c closes row r onto column c.
    logic [15:0] keys_pressed = '0;
    always_comb begin
        logic [3:0] f;
        f = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys_pressed[4*r+c] && kp.o_Col[c]) f[r] = 1'b1;
        kp.i_Fila = f;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse consumes one expected key code.
    always @(negedge clk) begin
        if (kp.o_Valida) begin
            pulses++;
            $display("pulse: tecla=%0d presionada=%0d t=%0t", kp.o_Tecla, kp.o_Presionada, $time);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got tecla %0d expected no pulse", kp.o_Tecla);
            end else begin
                check("tecla_on_pulse", int'(kp.o_Tecla), int'(exp_q.pop_front()));
                check("held_on_pulse", int'(kp.o_Presionada), 1);
            end
        end
    end

    // Returns on the first negedge of the next scan (column 0, divider 0).
    task automatic next_scan();
        int k;
        k = 0;
        @(negedge clk);
        while (kp.o_Col != 4'b1000 && k < 64) begin @(negedge clk); k++; end
        while (kp.o_Col != 4'b0001 && k < 64) begin @(negedge clk); k++; end
        if (k >= 64) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scan_timeout: got col %b expected rotation", kp.o_Col);
        end
    endtask

    // Apply a key set for one whole scan; returns just after the evaluation result is visible.
    task automatic run_scan(input logic [15:0] keys);
        keys_pressed = keys;
        next_scan();
        #2;
        $display("scan: keys=%h col=%b tecla=%0d presionada=%0d pulses=%0d",
                 keys, kp.o_Col, kp.o_Tecla, kp.o_Presionada, pulses);
    endtask

    initial begin
        int p;
        logic [3:0] exp_col;
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        logic [3:0] exp_col;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_col", int'(kp.o_Col), 1);
        check("rst_tecla", int'(kp.o_Tecla), 0);
        check("rst_valida", int'(kp.o_Valida), 0);
        check("rst_presionada", int'(kp.o_Presionada), 0);
        rst = 1'b0;

        // 1. Column rotation every 4 cycles
        check("col_start", int'(kp.o_Col), 1);
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            #1;
            if (n % 4 == 0) begin
                exp_col = 4'b0001 << ((n / 4) % 4);
                check($sformatf("col_rot_%0d", n), int'(kp.o_Col), int'(exp_col));
            end
        end
        run_scan(16'h0000);
        run_scan(16'h0000);
        check("idle_tecla", int'(kp.o_Tecla), 0);
        check("idle_no_pulse", pulses, 0);

        // 2. Key 9 (row 2, col 1) for 3 scans
        p = pulses;
        exp_q.push_back(4'd9);
        run_scan(16'h0200);
        check("press_scan1_no_pulse", pulses, p);
        check("press_scan1_not_held", int'(kp.o_Presionada), 0);
        run_scan(16'h0200);
        check("press_scan2_pulse", pulses, p + 1);
        run_scan(16'h0200);
        check("press_scan3_single_pulse", pulses, p + 1);
        check("press_tecla", int'(kp.o_Tecla), 9);
        check("press_held", int'(kp.o_Presionada), 1);

        // 3. One-scan gap, then full release
        run_scan(16'h0000);
        check("gap_still_held", int'(kp.o_Presionada), 1);
        run_scan(16'h0200);
        check("gap_held", int'(kp.o_Presionada), 1);
        check("gap_no_pulse", pulses, p + 1);
        run_scan(16'h0000);
        check("rel_scan1_held", int'(kp.o_Presionada), 1);
        run_scan(16'h0000);
        check("rel_scan2_released", int'(kp.o_Presionada), 0);
        check("rel_tecla_kept", int'(kp.o_Tecla), 9);

        // 4. Bounce: one scan only
        run_scan(16'h0200);
        run_scan(16'h0000);
        run_scan(16'h0000);
        check("bounce_no_pulse", pulses, p + 1);
        check("bounce_not_held", int'(kp.o_Presionada), 0);

        // 5. Ghosting: keys 0 and 5 together
        for (int s = 0; s < 4; s++) run_scan(16'h0021);
        check("multi_no_pulse", pulses, p + 1);
        check("multi_tecla_kept", int'(kp.o_Tecla), 9);
        check("multi_not_held", int'(kp.o_Presionada), 0);
        run_scan(16'h0000);

        // 6. Reset in the middle of debouncing key 6 (row 1, col 2)
        run_scan(16'h0040);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_col", int'(kp.o_Col), 1);
        check("midrst_tecla", int'(kp.o_Tecla), 0);
        check("midrst_valida", int'(kp.o_Valida), 0);
        check("midrst_presionada", int'(kp.o_Presionada), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        p = pulses;
        exp_q.push_back(4'd6);
        run_scan(16'h0040);
        check("after_rst_scan1_no_pulse", pulses, p);
        run_scan(16'h0040);
        check("after_rst_scan2_pulse", pulses, p + 1);
        check("after_rst_tecla", int'(kp.o_Tecla), 6);
        run_scan(16'h0000);
        run_scan(16'h0000);
        check("final_released", int'(kp.o_Presionada), 0);
        check("pending_expected", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
